// File: rtl/period_meter_pkg.sv
// Shared types and constants for the multi-channel period meter.
// Channel state encoding and the edge_mode encoding live here.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } chan_state_e;

  localparam logic [1:0] EDGE_RISE     = 2'b00;
  localparam logic [1:0] EDGE_FALL     = 2'b01;
  localparam logic [1:0] EDGE_BOTH     = 2'b10;
  localparam logic [1:0] EDGE_RISE_ALT = 2'b11;

  // Select which detected transitions count as a measurement edge.
  function automatic logic qual_edge(input logic [1:0] mode, input logic rise,
                                     input logic fall);
    logic q;
    case (mode)
      EDGE_FALL:                q = fall;
      EDGE_BOTH:                q = rise | fall;
      EDGE_RISE, EDGE_RISE_ALT: q = rise;
      default:                  q = rise;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/period_meter_chan.sv
// One period-measurement channel: synchroniser, edge detect, counter, FSM.
// PERIOD_METER_AVG_EN adds block averaging over 2^avg_sel periods.
module period_meter_chan
  import period_meter_pkg::*;
#(
  parameter int unsigned CW     = 32,
  parameter int unsigned SYNC_N = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sig,
  input  logic          chan_en,
  input  logic [1:0]    edge_mode,
  input  logic          mode_chg,
  input  logic [CW-1:0] timeout,
  input  logic [1:0]    avg_sel,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          upd,
  output logic          stale
);

  logic [SYNC_N-1:0] sync_q;
  logic              sig_d_q;
  logic              en_q;
  chan_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     period_d;
  logic              valid_d, upd_d, stale_d;
  logic              rise_c, fall_c, qual_c, tmo_c, en_rise_c, cnt_max_c;

`ifdef PERIOD_METER_AVG_EN
  localparam int unsigned AW    = CW + 3;
  localparam int unsigned BLK_W = 3;
  logic [AW-1:0]    acc_q, acc_d, sum_c;
  logic [BLK_W-1:0] blk_q, blk_d, blk_last_c;
`else
  logic unused_avg_c;
  assign unused_avg_c = ^avg_sel;
`endif

  // Synchroniser chain plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_N-2:0], sig};
      sig_d_q <= sync_q[SYNC_N-1];
      en_q    <= chan_en;
    end
  end

  assign rise_c    = sync_q[SYNC_N-1] & ~sig_d_q;
  assign fall_c    = ~sync_q[SYNC_N-1] & sig_d_q;
  assign qual_c    = qual_edge(edge_mode, rise_c, fall_c);
  assign en_rise_c = chan_en & ~en_q;
  assign cnt_max_c = &cnt_q;
  // Timeout only matters once the channel has seen an edge.
  assign tmo_c     = (timeout != '0) && (cnt_q == timeout) && (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period;
    valid_d  = valid;
    upd_d    = 1'b0;
    stale_d  = stale;
`ifdef PERIOD_METER_AVG_EN
    acc_d      = acc_q;
    blk_d      = blk_q;
    sum_c      = acc_q + AW'(cnt_q);
    blk_last_c = BLK_W'((4'd1 << avg_sel) - 4'd1);
`endif

    if (en_rise_c) begin
      valid_d = 1'b0;
      stale_d = 1'b0;
    end

    if (!chan_en) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef PERIOD_METER_AVG_EN
      acc_d = '0;
      blk_d = '0;
`endif
    end else begin
      if (qual_c)         cnt_d = CW'(1);
      else if (!cnt_max_c) cnt_d = cnt_q + CW'(1);

      if (mode_chg) begin
        state_d = IDLE;
`ifdef PERIOD_METER_AVG_EN
        acc_d = '0;
        blk_d = '0;
`endif
      end else if (qual_c) begin
        unique case (state_q)
          IDLE: state_d = ARMED;
          ARMED, RUN: begin
            state_d = RUN;
            stale_d = 1'b0;
`ifdef PERIOD_METER_AVG_EN
            if (blk_q == blk_last_c) begin
              period_d = CW'(sum_c >> avg_sel);
              valid_d  = 1'b1;
              upd_d    = 1'b1;
              acc_d    = '0;
              blk_d    = '0;
            end else begin
              acc_d = sum_c;
              blk_d = blk_q + BLK_W'(1);
            end
`else
            period_d = cnt_q;
            valid_d  = 1'b1;
            upd_d    = 1'b1;
`endif
          end
          default: state_d = IDLE;
        endcase
      end else if (tmo_c) begin
        period_d = '0;
        valid_d  = 1'b0;
        stale_d  = 1'b1;
        state_d  = IDLE;
`ifdef PERIOD_METER_AVG_EN
        acc_d = '0;
        blk_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      period <= '0;
      valid  <= 1'b0;
      upd    <= 1'b0;
      stale  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      period <= period_d;
      valid  <= valid_d;
      upd    <= upd_d;
      stale  <= stale_d;
    end
  end

`ifdef PERIOD_METER_AVG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      blk_q <= '0;
    end else begin
      acc_q <= acc_d;
      blk_q <= blk_d;
    end
  end
`endif

endmodule

// File: rtl/period_meter_mc.sv
// Multi-channel period meter top: NCH independent channels with shared
// edge_mode change detection. PERIOD_METER_AVG_EN enables period averaging.
module period_meter_mc
  import period_meter_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned CW     = 32,
  parameter int unsigned SYNC_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    sig,
  input  logic [NCH-1:0]    chan_en,
  input  logic [1:0]        edge_mode,
  input  logic [CW-1:0]     timeout,
  input  logic [1:0]        avg_sel,
  output logic [NCH*CW-1:0] period,
  output logic [NCH-1:0]    valid,
  output logic [NCH-1:0]    upd,
  output logic [NCH-1:0]    stale
);

  logic [1:0] mode_q;
  logic       mode_chg_c;

  // Any change of edge_mode restarts every channel from IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= EDGE_RISE;
    else        mode_q <= edge_mode;
  end

  assign mode_chg_c = (edge_mode != mode_q);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    period_meter_chan #(
      .CW     (CW),
      .SYNC_N (SYNC_N)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .sig       (sig[i]),
      .chan_en   (chan_en[i]),
      .edge_mode (edge_mode),
      .mode_chg  (mode_chg_c),
      .timeout   (timeout),
      .avg_sel   (avg_sel),
      .period    (period[i*CW +: CW]),
      .valid     (valid[i]),
      .upd       (upd[i]),
      .stale     (stale[i])
    );
  end

endmodule

// File: tb/tb_period_meter_mc.sv
// Self-checking bench for period_meter_mc: table-driven pulse trains with a
// per-channel scoreboard, plus hand sequences for timeout, reset and enables.
module tb_period_meter_mc;

  localparam int NCH = 4;
  localparam int CW = 32;
  localparam int SYNC_N = 2;
  localparam int CW8 = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    sig, chan_en, valid, upd, stale;
  logic [1:0]        edge_mode, avg_sel;
  logic [CW-1:0]     timeout;
  logic [NCH*CW-1:0] period;

  logic           sig8;
  logic [CW8-1:0] period8;
  logic [0:0]     valid8, upd8, stale8;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_q[NCH][$];
  logic [31:0] exp8_q[$];
  logic [NCH-1:0] upd_prev = '0;
  logic upd8_prev = 1'b0;

  always #5 clk = ~clk;

  period_meter_mc #(.NCH(NCH), .CW(CW), .SYNC_N(SYNC_N)) dut (
    .clk(clk), .reset(reset), .sig(sig), .chan_en(chan_en),
    .edge_mode(edge_mode), .timeout(timeout), .avg_sel(avg_sel),
    .period(period), .valid(valid), .upd(upd), .stale(stale)
  );

  period_meter_mc #(.NCH(1), .CW(CW8), .SYNC_N(SYNC_N)) dut8 (
    .clk(clk), .reset(reset), .sig(sig8), .chan_en(1'b1),
    .edge_mode(edge_mode), .timeout(8'd0), .avg_sel(avg_sel),
    .period(period8), .valid(valid8), .upd(upd8), .stale(stale8)
  );

  typedef struct {
    logic [3:0] mask;
    logic [1:0] mode;
    int         hi;
    int         lo;
    int         ncyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every upd pops one expected period for that channel.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (upd[i]) begin
        n_checks++;
        if (exp_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL upd_unexpected ch%0d: got upd with period %0d, expected no update",
                   i, period[i*CW +: CW]);
        end else begin
          logic [31:0] e;
          e = exp_q[i].pop_front();
          if (period[i*CW +: CW] !== e) begin
            n_fail++;
            $display("FAIL period ch%0d: got %0d, expected %0d", i, period[i*CW +: CW], e);
          end
        end
        n_checks++;
        if (!valid[i] || stale[i] || upd_prev[i]) begin
          n_fail++;
          $display("FAIL upd_flags ch%0d: got valid=%0b stale=%0b prev_upd=%0b, expected 1 0 0",
                   i, valid[i], stale[i], upd_prev[i]);
        end
      end
      upd_prev[i] = upd[i];
    end
    if (upd8[0]) begin
      n_checks++;
      if (exp8_q.size() == 0) begin
        n_fail++;
        $display("FAIL upd8_unexpected: got upd with period %0d, expected no update", period8);
      end else begin
        logic [31:0] e;
        e = exp8_q.pop_front();
        if (32'(period8) !== e) begin
          n_fail++;
          $display("FAIL period8: got %0d, expected %0d", period8, e);
        end
      end
      n_checks++;
      if (!valid8[0] || upd8_prev) begin
        n_fail++;
        $display("FAIL upd8_flags: got valid=%0b prev_upd=%0b, expected 1 0", valid8[0], upd8_prev);
      end
    end
    upd8_prev = upd8[0];
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NCH-1:0] mask, input int hi, input int lo);
    sig = sig | mask;
    cycles(hi);
    sig = sig & ~mask;
    cycles(lo);
  endtask

  task automatic push(input logic [NCH-1:0] mask, input logic [31:0] val);
    for (int c = 0; c < NCH; c++)
      if (mask[c]) exp_q[c].push_back(val);
  endtask

  task automatic idle_all(input logic [1:0] mode);
    chan_en   = '0;
    edge_mode = mode;
    cycles(2);
    chan_en = '1;
    cycles(2);
  endtask

  task automatic check_drained(input string name);
    cycles(6);
    for (int c = 0; c < NCH; c++) begin
      n_checks++;
      if (exp_q[c].size() != 0) begin
        n_fail++;
        $display("FAIL %s_missing_upd ch%0d: got %0d pending, expected 0", name, c, exp_q[c].size());
        exp_q[c].delete();
      end
    end
    n_checks++;
    if (exp8_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_upd8: got %0d pending, expected 0", name, exp8_q.size());
      exp8_q.delete();
    end
  endtask

  // Model the qualifying edge times of the pulse train and push their spacings.
  task automatic run_vec(input vec_t v);
    int ev[$];
    int t = 0;
    for (int k = 0; k < v.ncyc; k++) begin
      if (v.mode != 2'b01) ev.push_back(t);
      if (v.mode == 2'b01 || v.mode == 2'b10) ev.push_back(t + v.hi);
      t += v.hi + v.lo;
    end
    for (int j = 1; j < ev.size(); j++) push(v.mask, 32'(ev[j] - ev[j-1]));
    for (int k = 0; k < v.ncyc; k++) pulse(v.mask, v.hi, v.lo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b0;
    sig       = '0;
    sig8      = 1'b0;
    chan_en   = '0;
    edge_mode = 2'b00;
    timeout   = '0;
    avg_sel   = 2'd0;

    vecs[0] = '{4'b0001, 2'b00, 50, 50, 4};
    vecs[1] = '{4'b0010, 2'b01, 20, 17, 3};
    vecs[2] = '{4'b0100, 2'b10, 30, 70, 3};
    vecs[3] = '{4'b1000, 2'b11, 5, 6, 4};
    vecs[4] = '{4'b1111, 2'b00, 12, 13, 3};
    vecs[5] = '{4'b0001, 2'b10, 2, 3, 2};

    cycles(3);
    @(negedge clk);
    check("reset_period", period[31:0] | period[63:32] | period[95:64] | period[127:96], 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_upd", 32'(upd), 32'd0);
    check("reset_stale", 32'(stale), 32'd0);
    check("reset_period8", 32'(period8), 32'd0);
    @(posedge clk); #1;
    reset   = 1'b1;
    chan_en = '1;
    cycles(2);

    for (int v = 0; v < 6; v++) begin
      idle_all(vecs[v].mode);
      run_vec(vecs[v]);
      check_drained($sformatf("vec%0d", v));
    end

    // Narrow counter saturates on long gaps.
    idle_all(2'b00);
    exp8_q.push_back(32'd255);
    exp8_q.push_back(32'd200);
    sig8 = 1'b1; cycles(10); sig8 = 1'b0; cycles(290);
    sig8 = 1'b1; cycles(10); sig8 = 1'b0; cycles(190);
    sig8 = 1'b1; cycles(10); sig8 = 1'b0;
    check_drained("saturate");

    // Single edge then static: timeout fires 50 cycles after detection.
    timeout = 32'd50;
    idle_all(2'b00);
    sig[0] = 1'b1;
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      n = k;
      if (stale[0]) break;
    end
    check("timeout_latency", 32'(n), 32'(SYNC_N + 1 + 50));
    check("timeout_period", period[31:0], 32'd0);
    check("timeout_valid", 32'(valid[0]), 32'd0);
    @(posedge clk); #1;
    sig[0] = 1'b0;
    cycles(5);
    sig[0] = 1'b1; cycles(20);
    sig[0] = 1'b0; cycles(19);
    @(negedge clk);
    check("rearm_stale", 32'(stale[0]), 32'd1);
    check("rearm_valid", 32'(valid[0]), 32'd0);
    @(posedge clk); #1;
    push(4'b0001, 32'd40);
    sig[0] = 1'b1; cycles(20);
    sig[0] = 1'b0;
    check_drained("timeout");
    @(negedge clk);
    check("after_timeout_stale", 32'(stale[0]), 32'd0);

    // Edge landing exactly on the timeout count wins.
    timeout = 32'd40;
    idle_all(2'b00);
    push(4'b0001, 32'd40);
    push(4'b0001, 32'd40);
    pulse(4'b0001, 20, 20);
    pulse(4'b0001, 20, 20);
    pulse(4'b0001, 20, 6);
    check_drained("tmo_tie");
    timeout = '0;

    // edge_mode change between edges forces a re-arm.
    idle_all(2'b00);
    push(4'b0001, 32'd40);
    push(4'b0001, 32'd40);
    pulse(4'b0001, 20, 20);
    pulse(4'b0001, 20, 10);
    edge_mode = 2'b11;
    cycles(10);
    pulse(4'b0001, 20, 20);
    pulse(4'b0001, 20, 6);
    check_drained("mode_chg");

    // Disable holds results; re-enable clears valid/stale only.
    idle_all(2'b00);
    push(4'b0010, 32'd30);
    pulse(4'b0010, 15, 15);
    pulse(4'b0010, 15, 6);
    chan_en[1] = 1'b0;
    pulse(4'b0010, 10, 15);
    pulse(4'b0010, 10, 15);
    cycles(3);
    @(negedge clk);
    check("dis_period", period[63:32], 32'd30);
    check("dis_valid", 32'(valid[1]), 32'd1);
    chan_en[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("en_valid", 32'(valid[1]), 32'd0);
    check("en_stale", 32'(stale[1]), 32'd0);
    check("en_period", period[63:32], 32'd30);
    check_drained("enable");

    // Averaging over four periods (every period when averaging is absent).
    idle_all(2'b00);
    avg_sel = 2'd2;
`ifdef PERIOD_METER_AVG_EN
    push(4'b0001, 32'd100);
`else
    push(4'b0001, 32'd100);
    push(4'b0001, 32'd102);
    push(4'b0001, 32'd98);
    push(4'b0001, 32'd100);
`endif
    pulse(4'b0001, 50, 50);
    pulse(4'b0001, 50, 52);
    pulse(4'b0001, 50, 48);
    pulse(4'b0001, 50, 50);
    pulse(4'b0001, 50, 6);
    check_drained("avg");
    avg_sel = 2'd0;

    // One-cycle reset mid-run: outputs clear at once, two edges to next upd.
    idle_all(2'b00);
    push(4'b0001, 32'd100);
    pulse(4'b0001, 50, 50);
    pulse(4'b0001, 50, 50);
    @(negedge clk);
    check("pre_reset_valid", 32'(valid[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_period", period[31:0], 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);
    cycles(1);
    reset = 1'b1;
    cycles(2);
    push(4'b0001, 32'd60);
    pulse(4'b0001, 30, 30);
    pulse(4'b0001, 30, 6);
    check_drained("reset_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
